// File: rtl/bcd_countdown_timer.sv
// -----------------------------------------------------------------------------
// bcd_countdown_timer
// Four-digit BCD MM:SS down-counter for the alarm clock countdown/snooze timer.
// A preset is loaded with LD, Start runs the count, and each Tick strobe removes
// one second. Reaching 00:00 pulses Done and either parks in DONE (Expired high
// until Ack/LD) or, with AUTO_RELOAD, reloads the preset and keeps running.
//
// Ports:
//   Clk                 system clock, rising edge
//   Clr                 synchronous active-low reset
//   Tick                one-cycle 1 Hz enable strobe
//   LD / Start / Stop   load preset / run / pause
//   Ack                 acknowledge expiry
//   IN_MT..IN_SU        preset digits (BCD)
//   MT, MU, ST, SU      current count digits (BCD)
//   Running             high while counting
//   Done                one-cycle pulse on the edge the count reaches 00:00
//   Expired             high while parked at expiry
//   Err                 one-cycle pulse after a rejected load
// -----------------------------------------------------------------------------
module bcd_countdown_timer #(
   parameter int unsigned MIN_TENS_MAX = 9,
   parameter bit          AUTO_RELOAD  = 1'b0
) (
   input  logic       Clk,
   input  logic       Clr,
   input  logic       Tick,
   input  logic       LD,
   input  logic       Start,
   input  logic       Stop,
   input  logic       Ack,
   input  logic [3:0] IN_MT,
   input  logic [3:0] IN_MU,
   input  logic [3:0] IN_ST,
   input  logic [3:0] IN_SU,
   output logic [3:0] MT,
   output logic [3:0] MU,
   output logic [3:0] ST,
   output logic [3:0] SU,
   output logic       Running,
   output logic       Done,
   output logic       Expired,
   output logic       Err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Minutes-tens limit, clamped so a BCD digit can never exceed 9.
   localparam logic [3:0] MT_LIMIT = (MIN_TENS_MAX > 32'd9) ? 4'd9 : 4'(MIN_TENS_MAX);

   state_t     r_state, w_state;
   logic [3:0] r_mt, r_mu, r_st, r_su;
   logic [3:0] w_mt, w_mu, w_st, w_su;
   logic [3:0] r_pmt, r_pmu, r_pst, r_psu;
   logic [3:0] w_pmt, w_pmu, w_pst, w_psu;
   logic       r_done, w_done;
   logic       r_err, w_err;
   // Set on the expiry edge in auto-reload mode; the following edge reloads.
   logic       r_reload, w_reload;

   logic [3:0] w_dec_mt, w_dec_mu, w_dec_st, w_dec_su;
   logic       w_b_st, w_b_mu, w_b_mt;
   logic       w_count_zero, w_last_sec, w_preset_zero, w_load_ok;

   function automatic logic preset_ok(input logic [3:0] mt, input logic [3:0] mu,
                                      input logic [3:0] st, input logic [3:0] su);
      return (su <= 4'd9) && (st <= 4'd5) && (mu <= 4'd9) && (mt <= MT_LIMIT);
   endfunction

   // Borrow-chain decrement of the current count; zero digits wrap to 9/5.
   always_comb begin
      w_b_st   = (r_su == 4'd0);
      w_dec_su = w_b_st ? 4'd9 : (r_su - 4'd1);
      w_b_mu   = w_b_st && (r_st == 4'd0);
      if (w_b_st) begin
         w_dec_st = (r_st == 4'd0) ? 4'd5 : (r_st - 4'd1);
      end else begin
         w_dec_st = r_st;
      end
      w_b_mt = w_b_mu && (r_mu == 4'd0);
      if (w_b_mu) begin
         w_dec_mu = (r_mu == 4'd0) ? 4'd9 : (r_mu - 4'd1);
      end else begin
         w_dec_mu = r_mu;
      end
      // A borrow into MT only happens when the count is non-zero, so MT > 0.
      if (w_b_mt) begin
         w_dec_mt = r_mt - 4'd1;
      end else begin
         w_dec_mt = r_mt;
      end
   end

   assign w_count_zero  = (r_mt == 4'd0) && (r_mu == 4'd0) && (r_st == 4'd0) && (r_su == 4'd0);
   assign w_last_sec    = (r_mt == 4'd0) && (r_mu == 4'd0) && (r_st == 4'd0) && (r_su == 4'd1);
   assign w_preset_zero = (r_pmt == 4'd0) && (r_pmu == 4'd0) && (r_pst == 4'd0) && (r_psu == 4'd0);
   assign w_load_ok     = preset_ok(IN_MT, IN_MU, IN_ST, IN_SU);

   // Next-state, next-count and pulse generation (LD > reload > Ack > Stop > Start > Tick).
   always_comb begin
      w_state  = r_state;
      w_mt     = r_mt;
      w_mu     = r_mu;
      w_st     = r_st;
      w_su     = r_su;
      w_pmt    = r_pmt;
      w_pmu    = r_pmu;
      w_pst    = r_pst;
      w_psu    = r_psu;
      w_done   = 1'b0;
      w_err    = 1'b0;
      w_reload = 1'b0;
      if (LD) begin
         if (w_load_ok) begin
            w_mt    = IN_MT;
            w_mu    = IN_MU;
            w_st    = IN_ST;
            w_su    = IN_SU;
            w_pmt   = IN_MT;
            w_pmu   = IN_MU;
            w_pst   = IN_ST;
            w_psu   = IN_SU;
            w_state = S_IDLE;
         end else begin
            // Rejected load leaves everything alone, including a pending reload.
            w_err    = 1'b1;
            w_reload = r_reload;
         end
      end else if (r_reload) begin
         w_mt = r_pmt;
         w_mu = r_pmu;
         w_st = r_pst;
         w_su = r_psu;
         if (Stop) begin
            w_state = S_PAUSE;
         end else begin
            w_state = S_RUN;
         end
      end else begin
         case (r_state)
            S_DONE: begin
               if (Ack) begin
                  w_state = S_IDLE;
               end else begin
                  w_state = S_DONE;
               end
            end
            S_RUN: begin
               if (Stop) begin
                  w_state = S_PAUSE;
               end else if (Tick && !w_count_zero) begin
                  w_mt = w_dec_mt;
                  w_mu = w_dec_mu;
                  w_st = w_dec_st;
                  w_su = w_dec_su;
                  if (w_last_sec) begin
                     w_done = 1'b1;
                     if (AUTO_RELOAD && !w_preset_zero) begin
                        w_reload = 1'b1;
                     end else begin
                        w_state = S_DONE;
                     end
                  end else begin
                     w_state = S_RUN;
                  end
               end else begin
                  w_state = S_RUN;
               end
            end
            S_IDLE, S_PAUSE: begin
               if (!Stop && Start && !w_count_zero) begin
                  w_state = S_RUN;
               end else begin
                  w_state = r_state;
               end
            end
            default: begin
               w_state = S_IDLE;
            end
         endcase
      end
   end

   // State, count, preset and pulse registers with synchronous active-low clear.
   always_ff @(posedge Clk) begin
      if (!Clr) begin
         r_state  <= S_IDLE;
         r_mt     <= 4'd0;
         r_mu     <= 4'd0;
         r_st     <= 4'd0;
         r_su     <= 4'd0;
         r_pmt    <= 4'd0;
         r_pmu    <= 4'd0;
         r_pst    <= 4'd0;
         r_psu    <= 4'd0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_reload <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_mt     <= w_mt;
         r_mu     <= w_mu;
         r_st     <= w_st;
         r_su     <= w_su;
         r_pmt    <= w_pmt;
         r_pmu    <= w_pmu;
         r_pst    <= w_pst;
         r_psu    <= w_psu;
         r_done   <= w_done;
         r_err    <= w_err;
         r_reload <= w_reload;
      end
   end

   assign MT      = r_mt;
   assign MU      = r_mu;
   assign ST      = r_st;
   assign SU      = r_su;
   assign Running = (r_state == S_RUN);
   assign Expired = (r_state == S_DONE);
   assign Done    = r_done;
   assign Err     = r_err;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer. Three instances share one stimulus stream:
//   0: defaults, 1: MIN_TENS_MAX=5, 2: AUTO_RELOAD=1.
// A seconds-based model predicts every output each cycle; literal checks pin it.
module tb_bcd_countdown_timer;

   logic       Clk = 1'b0;
   logic       Clr = 1'b0;
   logic       Tick = 1'b0, LD = 1'b0, Start = 1'b0, Stop = 1'b0, Ack = 1'b0;
   logic [3:0] IN_MT = 4'd0, IN_MU = 4'd0, IN_ST = 4'd0, IN_SU = 4'd0;

   logic [3:0] o_mt [3];
   logic [3:0] o_mu [3];
   logic [3:0] o_st [3];
   logic [3:0] o_su [3];
   logic       o_run [3];
   logic       o_done [3];
   logic       o_exp [3];
   logic       o_err [3];

   int n_err = 0;
   int n_chk = 0;

   always #5 Clk = ~Clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      bcd_countdown_timer #(
         .MIN_TENS_MAX((g == 1) ? 5 : 9),
         .AUTO_RELOAD (g == 2)
      ) u_dut (
         .Clk(Clk), .Clr(Clr), .Tick(Tick), .LD(LD), .Start(Start), .Stop(Stop), .Ack(Ack),
         .IN_MT(IN_MT), .IN_MU(IN_MU), .IN_ST(IN_ST), .IN_SU(IN_SU),
         .MT(o_mt[g]), .MU(o_mu[g]), .ST(o_st[g]), .SU(o_su[g]),
         .Running(o_run[g]), .Done(o_done[g]), .Expired(o_exp[g]), .Err(o_err[g])
      );
   end

   // Model: count kept as total seconds; state 0 idle, 1 run, 2 pause, 3 done.
   int m_s [3];
   int m_p [3];
   int m_state [3];
   bit m_rl [3];
   bit m_done [3];
   bit m_err [3];
   int m_mtmax [3];
   bit m_ar [3];

   function automatic logic [15:0] to_bcd(input int s);
      logic [15:0] r;
      r[15:12] = 4'(s / 600);
      r[11:8]  = 4'((s / 60) % 10);
      r[7:4]   = 4'((s % 60) / 10);
      r[3:0]   = 4'(s % 10);
      return r;
   endfunction

   function automatic logic [15:0] dig(input int i);
      return {o_mt[i], o_mu[i], o_st[i], o_su[i]};
   endfunction

   task automatic model_step();
      for (int i = 0; i < 3; i++) begin
         m_done[i] = 1'b0;
         m_err[i]  = 1'b0;
         if (!Clr) begin
            m_s[i] = 0; m_p[i] = 0; m_state[i] = 0; m_rl[i] = 1'b0;
         end else if (LD) begin
            if (IN_SU <= 4'd9 && IN_ST <= 4'd5 && IN_MU <= 4'd9 && int'(IN_MT) <= m_mtmax[i]) begin
               m_s[i] = int'(IN_MT) * 600 + int'(IN_MU) * 60 + int'(IN_ST) * 10 + int'(IN_SU);
               m_p[i] = m_s[i];
               m_state[i] = 0;
               m_rl[i] = 1'b0;
            end else begin
               m_err[i] = 1'b1;
            end
         end else if (m_rl[i]) begin
            m_s[i] = m_p[i];
            m_rl[i] = 1'b0;
            if (Stop) m_state[i] = 2;
         end else if (m_state[i] == 3) begin
            if (Ack) m_state[i] = 0;
         end else if (m_state[i] == 1) begin
            if (Stop) m_state[i] = 2;
            else if (Tick && m_s[i] != 0) begin
               m_s[i] = m_s[i] - 1;
               if (m_s[i] == 0) begin
                  m_done[i] = 1'b1;
                  if (m_ar[i] && m_p[i] != 0) m_rl[i] = 1'b1;
                  else m_state[i] = 3;
               end
            end
         end else begin
            if (!Stop && Start && m_s[i] != 0) m_state[i] = 1;
         end
      end
   endtask

   task automatic compare_all();
      logic [19:0] act, exp;
      for (int i = 0; i < 3; i++) begin
         act = {dig(i), o_run[i], o_done[i], o_exp[i], o_err[i]};
         exp = {to_bcd(m_s[i]), m_state[i] == 1, m_done[i], m_state[i] == 3, m_err[i]};
         n_chk++;
         if (act !== exp) begin
            n_err++;
            $display("FAIL model_cmp dut%0d t=%0t got=%h expected=%h", i, $time, act, exp);
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge Clk);
      model_step();
      @(negedge Clk);
      compare_all();
   endtask

   task automatic do_ld(input logic [3:0] mt, input logic [3:0] mu,
                        input logic [3:0] st, input logic [3:0] su);
      IN_MT = mt; IN_MU = mu; IN_ST = st; IN_SU = su;
      LD = 1'b1; cycle(); LD = 1'b0;
   endtask

   task automatic do_start(); Start = 1'b1; cycle(); Start = 1'b0; endtask
   task automatic do_tick();  Tick  = 1'b1; cycle(); Tick  = 1'b0; endtask
   task automatic do_stop();  Stop  = 1'b1; cycle(); Stop  = 1'b0; endtask
   task automatic do_ack();   Ack   = 1'b1; cycle(); Ack   = 1'b0; endtask

   initial begin
      m_mtmax = '{9, 5, 9};
      m_ar    = '{1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         m_s[i] = 0; m_p[i] = 0; m_state[i] = 0; m_rl[i] = 1'b0;
         m_done[i] = 1'b0; m_err[i] = 1'b0;
      end
      @(negedge Clk);
      Clr = 1'b0;
      cycle(); cycle();
      chk("reset_digits", 32'(dig(0)), 32'h0000);
      chk("reset_flags", 32'({o_run[0], o_done[0], o_exp[0], o_err[0]}), 32'h0);
      Clr = 1'b1;

      // 01:00 countdown to expiry
      do_ld(4'd0, 4'd1, 4'd0, 4'd0);
      chk("load_0100", 32'(dig(0)), 32'h0100);
      do_start();
      chk("running_after_start", 32'(o_run[0]), 32'h1);
      do_tick();
      chk("first_tick_0059", 32'(dig(0)), 32'h0059);
      for (int k = 1; k <= 59; k++) begin
         do_tick();
         if (k < 59) cycle();
      end
      chk("expiry_digits", 32'(dig(0)), 32'h0000);
      chk("expiry_flags", 32'({o_run[0], o_done[0], o_exp[0]}), 32'h3);
      cycle();
      chk("done_one_cycle", 32'({o_done[0], o_exp[0]}), 32'h1);
      chk("autoreload_0100", 32'({dig(2), 3'b000, o_run[2]}), 32'h01001);
      do_tick();
      chk("tick_in_done", 32'({dig(0), 3'b000, o_exp[0]}), 32'h00001);
      do_ack();
      chk("ack_clears_expired", 32'(o_exp[0]), 32'h0);
      do_start();
      chk("start_at_zero", 32'({o_run[0], o_done[0]}), 32'h0);

      // Borrow chain
      do_ld(4'd1, 4'd0, 4'd0, 4'd0);
      do_start();
      do_tick();
      chk("borrow_1000", 32'(dig(0)), 32'h0959);
      do_ld(4'd0, 4'd0, 4'd1, 4'd0);
      do_start();
      do_tick();
      chk("borrow_0010", 32'(dig(0)), 32'h0009);

      // Rejected loads
      do_ld(4'd0, 4'd0, 4'd6, 4'd0);
      chk("err_st6", 32'({dig(0), 3'b000, o_err[0]}), 32'h00091);
      do_ld(4'd0, 4'd0, 4'd0, 4'hA);
      chk("err_suA", 32'({dig(0), 3'b000, o_err[0]}), 32'h00091);
      do_ld(4'd6, 4'd0, 4'd0, 4'd0);
      chk("mt6_limit5", 32'({dig(1), 3'b000, o_err[1]}), 32'h00091);
      chk("mt6_limit9", 32'({dig(0), 3'b000, o_err[0]}), 32'h60000);

      // Pause / resume priorities
      do_ld(4'd0, 4'd0, 4'd3, 4'd1);
      do_start();
      do_tick();
      chk("pause_pre", 32'(dig(0)), 32'h0030);
      Stop = 1'b1; Tick = 1'b1; cycle(); Stop = 1'b0; Tick = 1'b0;
      chk("stop_tick", 32'({dig(0), 3'b000, o_run[0]}), 32'h00300);
      for (int k = 0; k < 3; k++) do_tick();
      chk("pause_ticks", 32'(dig(0)), 32'h0030);
      do_start();
      do_tick();
      chk("resume_0029", 32'({dig(0), 3'b000, o_run[0]}), 32'h00291);
      do_stop();
      Start = 1'b1; Stop = 1'b1; cycle(); Start = 1'b0; Stop = 1'b0;
      chk("start_stop_pause", 32'(o_run[0]), 32'h0);

      // Auto reload and mid-run clear
      do_ld(4'd0, 4'd0, 4'd0, 4'd2);
      do_start();
      do_tick();
      chk("ar_0001", 32'(dig(2)), 32'h0001);
      do_tick();
      chk("ar_done", 32'({dig(2), 3'b000, o_done[2]}), 32'h00001);
      cycle();
      chk("ar_reload", 32'({dig(2), 2'b00, o_run[2], o_done[2]}), 32'h00022);
      do_tick();
      chk("ar_run_0001", 32'(dig(2)), 32'h0001);
      Clr = 1'b0; cycle(); Clr = 1'b1;
      chk("clr_midrun", 32'({dig(2), 1'b0, o_run[2], o_done[2], o_exp[2]}), 32'h00000);
      cycle(); cycle();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Four-digit BCD down-counter (MM:SS) for the alarm clock's countdown timer and snooze interval.
- It is the decrementing counterpart of the 0–9 up-counter digit chain.
- Loads a preset, counts down one second per Tick strobe, and flags expiry to the alarm/buzzer logic.
- Digits feed the display mux directly.

Parameters:
MIN_TENS_MAX, 9, largest legal minutes-tens digit at load (limits preset to MIN_TENS_MAX9:59)
AUTO_RELOAD, 0, 1 = on expiry reload stored preset and keep running; 0 = stop in DONE

Ports:
Clk  input  1  system clock, all state changes on rising edge
Clr  input  1  synchronous active-low reset
Tick  input  1  one-cycle 1 Hz enable strobe from prescaler
LD  input  1  load preset digits
Start  input  1  begin/resume counting
Stop  input  1  pause counting
Ack  input  1  acknowledge expiry
IN_MT, IN_MU, IN_ST, IN_SU  input  4 each  preset digits (min tens, min units, sec tens, sec units), BCD
MT, MU, ST, SU  output  4 each  current count digits, BCD
Running  output  1  high in RUN
Done  output  1  one-cycle pulse when count reaches 00:00
Expired  output  1  level, high in DONE until Ack/LD
Err  output  1  one-cycle pulse on rejected load

Behaviour:
- One clock; reset is synchronous and active-low. Clock port is Clk; reset port is Clr.
- Clr=0 at a rising edge:
  - all digits and stored preset become 0.
  - state becomes IDLE.
  - Running=0, Done=0, Expired=0, Err=0.
  - Reset mid-count aborts with no Done.
- States and outputs: IDLE, RUN, PAUSE, DONE. Running = (state==RUN). Expired = (state==DONE).
- Priority per edge: Clr > LD > Ack > Stop > Start > Tick.
- LD (any state):
  - Valid load: IN_SU<=9, IN_ST<=5, IN_MU<=9, IN_MT<=MIN_TENS_MAX. Digits and preset register get the inputs; state goes to IDLE.
  - Invalid load: digits, preset and state are unchanged; Err pulses the next cycle.
  - A valid LD in RUN or DONE aborts counting and clears Expired.
- Ack: in DONE goes to IDLE and the count stays 00:00. Ignored in other states.
- Stop: in RUN goes to PAUSE with the count held. Stop with Tick in the same cycle means no decrement. Stop with Start in the same cycle means Stop wins.
- Start:
  - In IDLE or PAUSE with count ≠ 00:00, goes to RUN on the next edge.
  - With count = 00:00 it is ignored: no Done, no state change.
  - Start in RUN is a no-op.
- Tick:
  - Acts only in RUN. Ticks in IDLE, PAUSE or DONE are ignored.
  - A Tick in the same cycle as the RUN entry edge is not counted.
- Decrement, one second per Tick, registered:
  - SU: if ≠0 then SU-1, else 9 with borrow.
  - ST on borrow: if ≠0 then ST-1, else 5 with borrow.
  - MU on borrow: if ≠0 then MU-1, else 9 with borrow.
  - MT on borrow: MT-1.
  - Zero is detected before decrementing, so no underflow is possible.
- Expiry: when a decrement makes the result 00:00, at that same edge:
  - Done=1 for exactly one cycle, aligned with the first 00:00 display cycle.
  - AUTO_RELOAD=0: state goes to DONE, Expired=1.
  - AUTO_RELOAD=1: the Done pulse still occurs. On the next edge the digits reload from the preset and the state stays RUN, Expired=0. If the preset is 00:00, go to DONE instead.
- Latency:
  - Outputs are registered.
  - LD/Tick effects are visible on digits one cycle after the sampling edge.
  - Running changes one cycle after Start/Stop.
- Digits are always valid BCD. Values ≥10 never appear on outputs.

Test Plan:
- Reset with Clr=0, then LD 01:00, Start, 1 Tick → digits 00:59, Running=1. Then 59 more Ticks → 00:00, Done pulses once, Expired=1, Running=0.
- Borrow chain: LD 10:00, Start, 1 Tick → 09:59. LD 00:10, Start, Tick → 00:09.
- Invalid loads are rejected:
  - LD with IN_ST=6 (00:60) → Err pulse, digits unchanged.
  - LD with IN_SU=4'hA → Err pulse, digits unchanged.
  - With MIN_TENS_MAX=5, LD 60:00 → Err pulse.
- Pause/resume and priorities:
  - In RUN at 00:30, assert Stop+Tick together → 00:30 held, state PAUSE.
  - Then Tick ×3 → still 00:30.
  - Then Start, Tick → 00:29.
  - Start+Stop together in PAUSE → stays PAUSE.
- Zero/expiry handling:
  - Start with count 00:00 → stays IDLE, no Done.
  - In DONE, Ack → IDLE, Expired=0.
  - Tick in DONE → no change.
- AUTO_RELOAD=1, preset 00:02, Start, Ticks → 00:01, 00:00 with Done pulse, then reload to 00:02 and keep running. Clr=0 mid-run → all zeros, IDLE, no Done.
